// File: rtl/front_pipe_regs.sv
// PC, IF/ID and ID/EX pipeline registers applying stall/flush requests.
// Optional STALL_CNT_EN adds a StallCount port counting Stall_D cycles.
module front_pipe_regs #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CTRL_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Stall_F,
   input  logic              Stall_D,
   input  logic              Flush_E,
   input  logic              Flush_D,
   input  logic [31:0]       PCNext_F,
   input  logic [31:0]       Instr_F,
   input  logic [31:0]       RegData1_D,
   input  logic [31:0]       RegData2_D,
   input  logic [31:0]       Imm_D,
   input  logic [4:0]        RsAddr_D,
   input  logic [4:0]        RtAddr_D,
   input  logic [4:0]        RdAddr_D,
   input  logic [CTRL_W-1:0] Ctrl_D,
   input  logic [1:0]        Mem2RegSEL_D,
   output logic [31:0]       PC_F,
   output logic [31:0]       Instr_D,
   output logic [31:0]       PCPlus4_D,
   output logic              Valid_D,
   output logic [31:0]       RegData1_E,
   output logic [31:0]       RegData2_E,
   output logic [31:0]       Imm_E,
   output logic [4:0]        RsAddr_E,
   output logic [4:0]        RtAddr_E,
   output logic [4:0]        RdAddr_E,
   output logic [CTRL_W-1:0] Ctrl_E,
   output logic [1:0]        Mem2RegSEL_E,
   output logic              Valid_E
`ifdef STALL_CNT_EN
   ,
   output logic [31:0]       StallCount
`endif
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

   typedef struct packed {
      logic [31:0]       rd1;
      logic [31:0]       rd2;
      logic [31:0]       imm;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [CTRL_W-1:0] ctrl;
      logic [1:0]        m2r;
      logic              valid;
   } idex_t;

   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   idex_t       idex_q, idex_d;

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;

      if (!Stall_F)
         pc_d = PCNext_F;

      // A stalled branch has not resolved, so Stall_D outranks Flush_D.
      if (!Stall_D) begin
         if (Flush_D) begin
            ifid_d = '0;
         end else begin
            ifid_d.instr    = Instr_F;
            ifid_d.pc_plus4 = pc_q + 32'd4;
            ifid_d.valid    = 1'b1;
         end
      end

      if (!Flush_E) begin
         idex_d.rd1   = RegData1_D;
         idex_d.rd2   = RegData2_D;
         idex_d.imm   = Imm_D;
         idex_d.rs    = RsAddr_D;
         idex_d.rt    = RtAddr_D;
         idex_d.rd    = RdAddr_D;
         idex_d.ctrl  = Ctrl_D;
         idex_d.m2r   = Mem2RegSEL_D;
         idex_d.valid = ifid_q.valid;
      end
   end

   // NOTE: sequential state uses non-blocking assignment; reset is synchronous and beats all requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= PC_RESET;
         ifid_q <= '0;
         idex_q <= '0;
      end else begin
         pc_q   <= pc_d;
         ifid_q <= ifid_d;
         idex_q <= idex_d;
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (Stall_D)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign StallCount = stall_cnt_q;
`endif

   assign PC_F         = pc_q;
   assign Instr_D      = ifid_q.instr;
   assign PCPlus4_D    = ifid_q.pc_plus4;
   assign Valid_D      = ifid_q.valid;
   assign RegData1_E   = idex_q.rd1;
   assign RegData2_E   = idex_q.rd2;
   assign Imm_E        = idex_q.imm;
   assign RsAddr_E     = idex_q.rs;
   assign RtAddr_E     = idex_q.rt;
   assign RdAddr_E     = idex_q.rd;
   assign Ctrl_E       = idex_q.ctrl;
   assign Mem2RegSEL_E = idex_q.m2r;
   assign Valid_E      = idex_q.valid;

endmodule

// File: doc/front_pipe_regs.md
# front_pipe_regs

Front-end pipeline register bank for the 5-stage MIPS-style core: the PC register, the IF/ID register and the ID/EX register. It consumes the stall/flush requests produced by the load-use hazard detection logic (Stall_F, Stall_D, Flush_E) and the branch redirect flush (Flush_D). It holds, advances or bubbles each stage on every clock edge. It is the only place where those requests become state changes.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 8, width of the decoded control bundle carried from D to E.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Stall_F  in  1  hold PC_F.
- Stall_D  in  1  hold the IF/ID register.
- Flush_E  in  1  load a bubble into the ID/EX register.
- Flush_D  in  1  branch/jump redirect; load a bubble into the IF/ID register.
- PCNext_F  in  32  next-PC value (PC+4 or redirect target).
- Instr_F  in  32  instruction memory output for PC_F.
- RegData1_D, RegData2_D  in  32 each  register file read data.
- Imm_D  in  32  sign/zero-extended immediate.
- RsAddr_D, RtAddr_D, RdAddr_D  in  5 each  register fields decoded from Instr_D.
- Ctrl_D  in  CTRL_W  decoded control bundle.
- Mem2RegSEL_D  in  2  writeback source select (1 = load).
- PC_F  out  32  current fetch PC.
- Instr_D, PCPlus4_D  out  32 each  IF/ID contents.
- Valid_D  out  1  IF/ID holds a real instruction.
- RegData1_E, RegData2_E, Imm_E  out  32 each.
- RsAddr_E, RtAddr_E, RdAddr_E  out  5 each.
- Ctrl_E  out  CTRL_W.
- Mem2RegSEL_E  out  2.
- Valid_E  out  1  ID/EX holds a real instruction.
- StallCount  out  32  only with STALL_CNT_EN.

## Operation
- Reset:
  - PC_F = PC_RESET.
  - Every IF/ID and ID/EX field = 0, including Valid_D and Valid_E.
  - StallCount = 0.
  - Reset overrides every stall and flush input.
- PC register:
  - Stall_F = 1: PC_F holds.
  - Otherwise: PC_F <= PCNext_F.
- IF/ID register, first matching rule wins:
  1. Stall_D = 1: hold all fields. Stall beats Flush_D, because a stalled branch has not resolved yet.
  2. Flush_D = 1: Instr_D <= 0 (NOP), PCPlus4_D <= 0, Valid_D <= 0.
  3. Otherwise: Instr_D <= Instr_F, PCPlus4_D <= PC_F + 4 (32-bit wrap-around, so 32'hFFFF_FFFC gives 0), Valid_D <= 1.
- ID/EX register, first matching rule wins:
  1. Flush_E = 1: load a bubble. Every data and address field = 0, Ctrl_E = 0, Mem2RegSEL_E = 0, Valid_E = 0.
     - Because RtAddr_E = 0 and Mem2RegSEL_E = 0, the bubble can never itself trigger a further load-use stall.
  2. Otherwise: capture every *_D input and Valid_D into its *_E counterpart. ID/EX has no hold; a stall in D always pairs with Flush_E.
- A load-use hazard asserts Stall_F, Stall_D and Flush_E together. The result is exactly one bubble inserted into E while F and D repeat.
- Any stall/flush combination is legal and follows the rules above independently per register. Flush_E without Stall_D is one case: the D instruction is lost, and the block does not guard against it.

## Timing
- Every output is a register output; there is no combinational path from any input to any output.
- Stall or flush inputs sampled at edge N take effect on the outputs after edge N.
- Latency: an instruction presented on Instr_F at edge N appears on Instr_D after edge N and on the E outputs after edge N+1, provided there are no stalls.
- A stall lasting k cycles delays downstream arrival by exactly k cycles and inserts k bubbles into E.
- Reset asserted mid-stall: after that edge, all state equals the reset values. The first PC fetched after reset deasserts is PC_RESET.

## Configuration
- STALL_CNT_EN:
  - Defined: StallCount exists. It increments by 1 on every edge where reset = 0 and Stall_D = 1, wraps from 32'hFFFF_FFFF to 0, and is cleared by reset.
  - Undefined: the StallCount port and its counter are omitted entirely. All other behaviour is identical.

## Test plan
- Reset release, PC_RESET = 0, PCNext_F = PC_F + 4, no stalls → PC_F sequence 0, 4, 8. Instr_D follows Instr_F one cycle later with Valid_D = 1; the E outputs follow one cycle after that.
- Load in E (Mem2RegSEL_E = 1, RtAddr_E = 8), dependent add in D: hold Stall_F/Stall_D/Flush_E high for 1 cycle → PC_F and Instr_D unchanged for one cycle, E receives a bubble (Valid_E = 0, Ctrl_E = 0), then the add reaches E with its original fields.
- Flush_D = 1 with Stall_D = 0 → Instr_D = 0, Valid_D = 0 next cycle. Flush_D = 1 with Stall_D = 1 → IF/ID holds unchanged.
- Reset asserted during a 3-cycle stall (second cycle) → next cycle PC_F = PC_RESET and all D/E fields are 0. After release, fetch resumes from PC_RESET.
- PC_F = 32'hFFFF_FFFC, no stall → PCPlus4_D = 0 next cycle.
- With STALL_CNT_EN: 5 non-consecutive Stall_D cycles → StallCount = 5. Reset → 0. Preload to 32'hFFFF_FFFF and stall once → 0.
